// File: rtl/overload_tx.sv
// Transmit side of the CAN overload frame: drives the flag and delimiter on canTX
// and watches canRX for bit errors, superposition, delimiter errors and restarts.
module overload_tx #(
  parameter int FLAG_LEN      = 6,
  parameter int DELIM_LEN     = 8,
  parameter int SUPER_MAX     = 7,
  parameter int MAX_OVERLOADS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       samplePoint,
  input  logic       canRX,
  input  logic       startOverload,
  output logic       canTX,
  output logic       busy,
  output logic       endOverload,
  output logic       bitError,
  output logic       formError,
  output logic [1:0] overloadNum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLAG  = 2'd1;
  localparam logic [1:0] S_SUPER = 2'd2;
  localparam logic [1:0] S_DELIM = 2'd3;

  localparam logic [4:0] FLAG_LAST  = 5'(FLAG_LEN - 1);
  localparam logic [4:0] SUPER_LAST = 5'(SUPER_MAX - 1);
  localparam logic [4:0] DELIM_LAST = 5'(DELIM_LEN - 1);
  localparam logic [1:0] NUM_MAX    = 2'(MAX_OVERLOADS);

  logic [1:0] r_state;
  logic [4:0] r_count;
  logic       r_canTX;
  logic       r_busy;
  logic       r_endOverload;
  logic       r_bitError;
  logic       r_formError;
  logic [1:0] r_overloadNum;

  logic [4:0] w_countInc;
  logic       w_sample;

  // The counter saturates rather than wrapping so a stuck bus can never alias a valid count.
  assign w_countInc = (r_count == 5'h1f) ? r_count : r_count + 5'd1;
  assign w_sample   = samplePoint;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_count       <= 5'd0;
      r_canTX       <= 1'b1;
      r_busy        <= 1'b0;
      r_endOverload <= 1'b0;
      r_bitError    <= 1'b0;
      r_formError   <= 1'b0;
      r_overloadNum <= 2'd0;
    end else begin
      r_endOverload <= 1'b0;
      r_bitError    <= 1'b0;
      r_formError   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A sample coinciding with the start request is not a flag bit.
          if (startOverload) begin
            r_state       <= S_FLAG;
            r_canTX       <= 1'b0;
            r_busy        <= 1'b1;
            r_count       <= 5'd0;
            r_overloadNum <= 2'd1;
          end
        end

        S_FLAG: begin
          if (w_sample) begin
            if (canRX) begin
              r_bitError <= 1'b1;
              r_state    <= S_IDLE;
              r_canTX    <= 1'b1;
              r_busy     <= 1'b0;
              r_count    <= 5'd0;
            end else if (r_count >= FLAG_LAST) begin
              r_state <= S_SUPER;
              r_canTX <= 1'b1;
              r_count <= 5'd0;
            end else begin
              r_count <= w_countInc;
            end
          end
        end

        S_SUPER: begin
          // The first recessive bit here already counts as delimiter bit one.
          if (w_sample) begin
            if (canRX) begin
              r_state <= S_DELIM;
              r_count <= 5'd1;
            end else if (r_count >= SUPER_LAST) begin
              r_formError <= 1'b1;
              r_state     <= S_IDLE;
              r_canTX     <= 1'b1;
              r_busy      <= 1'b0;
              r_count     <= 5'd0;
            end else begin
              r_count <= w_countInc;
            end
          end
        end

        S_DELIM: begin
          if (w_sample) begin
            if (r_count >= DELIM_LAST) begin
              if (canRX) begin
                r_endOverload <= 1'b1;
                r_state       <= S_IDLE;
                r_canTX       <= 1'b1;
                r_busy        <= 1'b0;
                r_count       <= 5'd0;
                r_overloadNum <= 2'd0;
              end else if (r_overloadNum < NUM_MAX) begin
                r_state       <= S_FLAG;
                r_canTX       <= 1'b0;
                r_count       <= 5'd0;
                r_overloadNum <= r_overloadNum + 2'd1;
              end else begin
                r_formError <= 1'b1;
                r_state     <= S_IDLE;
                r_canTX     <= 1'b1;
                r_busy      <= 1'b0;
                r_count     <= 5'd0;
              end
            end else if (canRX) begin
              r_count <= w_countInc;
            end else begin
              r_formError <= 1'b1;
              r_state     <= S_IDLE;
              r_canTX     <= 1'b1;
              r_busy      <= 1'b0;
              r_count     <= 5'd0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_canTX <= 1'b1;
          r_busy  <= 1'b0;
          r_count <= 5'd0;
        end
      endcase
    end
  end

  assign canTX       = r_canTX;
  assign busy        = r_busy;
  assign endOverload = r_endOverload;
  assign bitError    = r_bitError;
  assign formError   = r_formError;
  assign overloadNum = r_overloadNum;

endmodule

// File: tb/tb_overload_tx.sv
// Scoreboard bench for overload_tx: scenarios are built from whole-frame bus patterns,
// the expected outcome is queued and a monitor checks each completion/error pulse.
module tb_overload_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       samplePoint = 1'b0;
  logic       canRX = 1'b1;
  logic       startOverload = 1'b0;
  logic       canTX;
  logic       busy;
  logic       endOverload;
  logic       bitError;
  logic       formError;
  logic [1:0] overloadNum;

  overload_tx dut (
    .clock(clock), .reset(reset), .samplePoint(samplePoint), .canRX(canRX),
    .startOverload(startOverload), .canTX(canTX), .busy(busy),
    .endOverload(endOverload), .bitError(bitError), .formError(formError),
    .overloadNum(overloadNum)
  );

  always #5 clock = ~clock;

  // kind: 0 endOverload, 1 bitError, 2 formError
  typedef struct {
    int kind;
    int idx;
    int num;
    int low;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int nChecks = 0;
  int nPass = 0;
  int drvSamples = 0;
  int monSamples = 0;
  int monLow = 0;

  function automatic void check(input string name, input int act, input int req);
    nChecks++;
    if (act == req) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Monitor: pulses seen here come from the previous edge; samplePoint is for the next edge.
  always @(negedge clock) begin
    if (reset) begin
      monLow = 0;
    end else begin
      if (endOverload || bitError || formError) begin
        if (expQ.size() == 0) begin
          check("unexpectedPulse", 1, 0);
        end else begin
          monE = expQ.pop_front();
          check("eventKind", endOverload ? 0 : (bitError ? 1 : 2), monE.kind);
          check("singlePulse", int'(endOverload) + int'(bitError) + int'(formError), 1);
          check("eventSample", monSamples, monE.idx);
          check("flagLowSamples", monLow, monE.low);
          check("overloadNum", int'(overloadNum), monE.num);
          check("canTxAfter", int'(canTX), 1);
          check("busyAfter", int'(busy), 0);
        end
        monLow = 0;
      end
      if (samplePoint) begin
        monSamples++;
        if (!canTX) monLow++;
      end
    end
  end

  task automatic tick(input logic sp, input logic rx, input logic st);
    @(posedge clock);
    #1;
    samplePoint   = sp;
    canRX         = rx;
    startOverload = st;
    if (sp) drvSamples++;
  endtask

  task automatic checkOutput(input string name, input logic txReq, input logic busyReq, input int numReq);
    @(negedge clock);
    check({name, ".canTX"}, int'(canTX), int'(txReq));
    check({name, ".busy"}, int'(busy), int'(busyReq));
    check({name, ".pulses"}, int'(endOverload) + int'(bitError) + int'(formError), 0);
    check({name, ".overloadNum"}, int'(overloadNum), numReq);
  endtask

  // One overload episode: nFrames frames, the last one ending per kind
  // (0 clean end, 1 bit error at flag bit p, 2 superposition overrun,
  //  3 dominant at delimiter bit p, 4 restart beyond the allowed count).
  task automatic applyStimulus(input int kind, input int nFrames, input int s, input int p);
    logic bits[$];
    exp_t e;
    int waitCnt;
    bit isLast;
    e.low = 0;
    e.num = nFrames;
    e.kind = 2;
    for (int f = 1; f <= nFrames; f++) begin
      isLast = (f == nFrames);
      if (isLast && kind == 1) begin
        for (int i = 1; i < p; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        e.low += p;
        e.kind = 1;
      end else begin
        for (int i = 0; i < 6; i++) bits.push_back(1'b0);
        e.low += 6;
        if (isLast && kind == 2) begin
          for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        end else begin
          for (int i = 0; i < s; i++) bits.push_back(1'b0);
          if (!isLast || kind == 4) begin
            for (int i = 0; i < 7; i++) bits.push_back(1'b1);
            bits.push_back(1'b0);
          end else if (kind == 0) begin
            for (int i = 0; i < 8; i++) bits.push_back(1'b1);
            e.kind = 0;
            e.num = 0;
          end else begin
            for (int i = 1; i < p; i++) bits.push_back(1'b1);
            bits.push_back(1'b0);
          end
        end
      end
    end

    tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    checkOutput("startLatency", 1'b0, 1'b1, 1);
    for (int i = 0; i < bits.size(); i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--)
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      if (i == bits.size() - 1) begin
        e.idx = drvSamples + 1;
        expQ.push_back(e);
      end
      tick(1'b1, bits[i], 1'($urandom_range(0, 3) == 0));
    end
    tick(1'b0, 1'b1, 1'b0);
    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 10) begin
      @(negedge clock);
      waitCnt++;
    end
    if (expQ.size() != 0) begin
      check("eventTimeout", expQ.size(), 0);
      expQ.delete();
    end
    tick(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind, nFrames;
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    checkOutput("resetHeld", 1'b1, 1'b0, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("resetReleased", 1'b1, 1'b0, 0);

    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 3, 0);
    applyStimulus(1, 1, 0, 3);
    checkOutput("numHeldAfterError", 1'b1, 1'b0, 1);
    applyStimulus(2, 1, 0, 0);
    applyStimulus(0, 2, 0, 0);
    applyStimulus(4, 2, 2, 0);
    applyStimulus(3, 1, 0, 4);
    applyStimulus(3, 2, 6, 7);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 4);
      nFrames = (kind == 4) ? 2 : $urandom_range(1, 2);
      applyStimulus(kind, nFrames, $urandom_range(0, 6),
                    (kind == 1) ? $urandom_range(1, 6) : $urandom_range(2, 7));
    end

    // Reset in the middle of the flag
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    samplePoint = 1'b0;
    @(negedge clock);
    checkOutput("midFlagReset", 1'b1, 1'b0, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(0, 1, 1, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/overload_tx.md
Name: overload_tx

Overview:
- Transmit side of the CAN overload frame: drives the overload flag and overload delimiter onto canTX.
- Monitors canRX each bit for bit errors, superposition by other nodes' flags, delimiter form errors, and back-to-back overload restart.
- Sits beside the frame-maker receive FSM. The interframe logic requests an overload; this block owns canTX until it signals completion or an error.

Parameters:
- FLAG_LEN, 6, dominant bits in the overload flag.
- DELIM_LEN, 8, recessive bits in the delimiter, counting the first recessive bit seen after superposition.
- SUPER_MAX, 7, maximum dominant bits tolerated after own flag before formError.
- MAX_OVERLOADS, 2, maximum consecutive overload frames (including restarts).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- samplePoint  input  1  one-clock strobe at each bit sample point
- canRX  input  1  sampled bus value (0 = dominant)
- startOverload  input  1  one-clock request to begin an overload frame
- canTX  output  1  driven bus value (1 = recessive)
- busy  output  1  high while the block owns canTX
- endOverload  output  1  one-clock pulse when the delimiter completes
- bitError  output  1  one-clock pulse when canRX is recessive while own dominant flag is driven
- formError  output  1  one-clock pulse on superposition overrun, illegal dominant in delimiter, or restart beyond MAX_OVERLOADS
- overloadNum  output  2  overload frames started since the last IDLE exit

Behaviour:
- Reset: state=IDLE, canTX=1, busy=0, endOverload=0, bitError=0, formError=0, overloadNum=0, count=0. Reset in any state returns here on the next edge.
- Only register updates occur on clock. All bit decisions occur on clock edges where samplePoint=1.
- count is 5 bits and saturates; it never wraps.
- Pulse outputs are registered. Each is high for exactly one clock and is otherwise 0.
- IDLE:
  - startOverload=1 -> next edge: state=FLAG, canTX=0, busy=1, count=0, overloadNum=1.
  - Latency from startOverload to canTX low is 1 clock.
  - startOverload while busy is ignored.
- FLAG, on samplePoint:
  - canRX=1 -> bitError pulse, state=IDLE, canTX=1, busy=0.
  - canRX=0, count<FLAG_LEN-1 -> count++.
  - canRX=0, count==FLAG_LEN-1 -> state=SUPER, canTX=1, count=0.
- SUPER, on samplePoint (canTX stays 1):
  - canRX=0, count<SUPER_MAX-1 -> count++.
  - canRX=0, count==SUPER_MAX-1 -> formError, IDLE.
  - canRX=1 -> state=DELIM, count=1.
- DELIM, on samplePoint:
  - canRX=1, count<DELIM_LEN-1 -> count++.
  - canRX=1, count==DELIM_LEN-1 -> endOverload pulse, IDLE, busy=0, overloadNum=0.
  - canRX=0, count<DELIM_LEN-1 -> formError, IDLE.
  - canRX=0, count==DELIM_LEN-1 (dominant on the last delimiter bit), overloadNum<MAX_OVERLOADS -> state=FLAG, canTX=0, count=0, overloadNum++.
  - canRX=0, count==DELIM_LEN-1, overloadNum==MAX_OVERLOADS -> formError, IDLE.
- Every transition into IDLE forces canTX=1 and busy=0 on the same edge.
- overloadNum holds its value in IDLE after an error, until the next start.
- samplePoint and startOverload together in IDLE: start is taken; that sample is not evaluated as a flag bit.
- canTX never toggles except on the start edge or a samplePoint edge.

Test Plan:
- Clean frame: after reset, canTX=1 and busy=0. Pulse start; canRX mirrors canTX for 6 bits, then recessive for 8 bits. Required: canTX=0 for exactly 6 samplePoints, then 1; endOverload pulses once at the 14th samplePoint; busy drops on the same edge; overloadNum returns to 0.
- Superposition: canRX held dominant for 3 extra bits after own flag, then recessive for 8 bits. Required: no error; endOverload fires at samplePoint 6+3+8=17.
- Bit error: canRX=1 at the 3rd flag sample. Required: bitError pulse on that edge, canTX=1, busy=0, no endOverload.
- Superposition overrun: canRX dominant for 7 samples after the flag. Required: formError on the 7th, IDLE.
- Restart: canRX dominant at the 8th delimiter bit. Required: canTX=0 on that edge, overloadNum=2, a second full frame follows, then endOverload. A third dominant at the 8th delimiter bit gives formError.
- Early dominant in the delimiter at bit 4 gives formError. Reset asserted mid-FLAG gives canTX=1, busy=0, and all outputs at reset values on the next edge. startOverload while busy has no effect.
